// File: rtl/div_unit_if.sv
// Start/ready handshake between the execute stage (master) and the divider (slave).
`timescale 1ns/1ps
interface div_unit_if #(
  parameter int unsigned DATA_W = 32
);
  logic                  div_start;
  logic                  div_signed;
  logic                  div_cancel;
  logic [DATA_W-1:0]     div_opdata1;
  logic [DATA_W-1:0]     div_opdata2;
  logic                  div_ready;
  logic                  div_busy;
  logic                  div_by_zero;
  logic [2*DATA_W-1:0]   div_result;

  modport master (
    output div_start, div_signed, div_cancel, div_opdata1, div_opdata2,
    input  div_ready, div_busy, div_by_zero, div_result
  );

  modport slave (
    input  div_start, div_signed, div_cancel, div_opdata1, div_opdata2,
    output div_ready, div_busy, div_by_zero, div_result
  );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned integer divider returning {remainder, quotient}.
// Define DIV_RADIX4_EN for the radix-4 iteration (2 quotient bits per cycle).
`timescale 1ns/1ps
module div_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input  logic      cpu_clk_50M,
  input  logic      cpu_rst_n,
  div_unit_if.slave div_if
);

  localparam int unsigned RES_W = 2 * DATA_W;
`ifdef DIV_RADIX4_EN
  localparam int unsigned STEP  = 2;
`else
  localparam int unsigned STEP  = 1;
`endif

  typedef enum logic [1:0] {
    S_FREE    = 2'b00,
    S_BY_ZERO = 2'b01,
    S_ON      = 2'b10,
    S_END     = 2'b11
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_signed;
  logic               r_sign1;
  logic               r_sign2;
  logic [DATA_W-1:0]  r_dvs;
  logic [DATA_W-1:0]  r_rem;
  logic [DATA_W-1:0]  r_quo;
  logic               r_ready;
  logic               r_busy;
  logic               r_by_zero;
  logic [RES_W-1:0]   r_result;

  logic [DATA_W-1:0]  w_abs1;
  logic [DATA_W-1:0]  w_abs2;
  logic [DATA_W-1:0]  w_rem_nx;
  logic [DATA_W-1:0]  w_quo_nx;
  logic [DATA_W-1:0]  w_quo_fix;
  logic [DATA_W-1:0]  w_rem_fix;

  // Operand magnitudes taken from the live inputs at acceptance.
  assign w_abs1 = (div_if.div_signed && div_if.div_opdata1[DATA_W-1])
                ? (~div_if.div_opdata1 + DATA_W'(1)) : div_if.div_opdata1;
  assign w_abs2 = (div_if.div_signed && div_if.div_opdata2[DATA_W-1])
                ? (~div_if.div_opdata2 + DATA_W'(1)) : div_if.div_opdata2;

`ifdef DIV_RADIX4_EN
  logic [DATA_W+1:0]  r_d2;
  logic [DATA_W+1:0]  r_d3;
  logic [DATA_W+1:0]  w_rem_sh;
  logic [1:0]         w_qd;

  // Pick the largest multiple of the divisor that still fits.
  assign w_rem_sh = {r_rem, r_quo[DATA_W-1 -: 2]};
  always_comb begin
    w_rem_nx = w_rem_sh[DATA_W-1:0];
    w_qd     = 2'd0;
    if (w_rem_sh >= r_d3) begin
      w_rem_nx = DATA_W'(w_rem_sh - r_d3);
      w_qd     = 2'd3;
    end else if (w_rem_sh >= r_d2) begin
      w_rem_nx = DATA_W'(w_rem_sh - r_d2);
      w_qd     = 2'd2;
    end else if (w_rem_sh >= {2'b00, r_dvs}) begin
      w_rem_nx = DATA_W'(w_rem_sh - {2'b00, r_dvs});
      w_qd     = 2'd1;
    end
  end
  assign w_quo_nx = {r_quo[DATA_W-3:0], w_qd};

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      r_d2 <= '0;
      r_d3 <= '0;
    end else if (r_state == S_FREE && div_if.div_start && !div_if.div_cancel) begin
      r_d2 <= {1'b0, w_abs2, 1'b0};
      r_d3 <= {2'b00, w_abs2} + {1'b0, w_abs2, 1'b0};
    end
  end
`else
  logic [DATA_W:0]    w_rem_sh;
  logic               w_ge;

  // Restoring step: trial subtract, keep the difference when non-negative.
  assign w_rem_sh = {r_rem, r_quo[DATA_W-1]};
  assign w_ge     = (w_rem_sh >= {1'b0, r_dvs});
  assign w_rem_nx = w_ge ? DATA_W'(w_rem_sh - {1'b0, r_dvs}) : w_rem_sh[DATA_W-1:0];
  assign w_quo_nx = {r_quo[DATA_W-2:0], w_ge};
`endif

  // Quotient is negative when signs differ; remainder follows the dividend.
  assign w_quo_fix = (r_signed && (r_sign1 ^ r_sign2)) ? (~r_quo + DATA_W'(1)) : r_quo;
  assign w_rem_fix = (r_signed && r_sign1)             ? (~r_rem + DATA_W'(1)) : r_rem;

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      r_state   <= S_FREE;
      r_cnt     <= '0;
      r_signed  <= 1'b0;
      r_sign1   <= 1'b0;
      r_sign2   <= 1'b0;
      r_dvs     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
      r_by_zero <= 1'b0;
      r_result  <= '0;
    end else if (div_if.div_cancel) begin
      r_state   <= S_FREE;
      r_cnt     <= '0;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
      r_by_zero <= 1'b0;
      r_result  <= '0;
    end else begin
      case (r_state)
        S_FREE: begin
          if (div_if.div_start) begin
            r_signed <= div_if.div_signed;
            r_sign1  <= div_if.div_opdata1[DATA_W-1];
            r_sign2  <= div_if.div_opdata2[DATA_W-1];
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            if (div_if.div_opdata2 == '0) begin
              r_state <= S_BY_ZERO;
            end else begin
              r_state <= S_ON;
              r_dvs   <= w_abs2;
              r_rem   <= '0;
              r_quo   <= w_abs1;
            end
          end
        end
        S_BY_ZERO: begin
          r_state   <= S_END;
          r_ready   <= 1'b1;
          r_by_zero <= 1'b1;
          r_result  <= '0;
        end
        S_ON: begin
          if (r_cnt == CNT_W'(DATA_W)) begin
            r_state  <= S_END;
            r_ready  <= 1'b1;
            r_result <= {w_rem_fix, w_quo_fix};
          end else begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
            r_cnt <= r_cnt + CNT_W'(STEP);
          end
        end
        S_END: begin
          if (!div_if.div_start) begin
            r_state   <= S_FREE;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
            r_by_zero <= 1'b0;
            r_result  <= '0;
          end
        end
        default: r_state <= S_FREE;
      endcase
    end
  end

  assign div_if.div_ready   = r_ready;
  assign div_if.div_busy    = r_busy;
  assign div_if.div_by_zero = r_by_zero;
  assign div_if.div_result  = r_result;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: arithmetic reference model plus directed vectors.
`timescale 1ns/1ps
module tb_div_unit;

`ifdef DIV_RADIX4_EN
  localparam int LAT = 17;
`else
  localparam int LAT = 33;
`endif

  logic clk;
  logic rst_n;

  div_unit_if #(.DATA_W(32)) u_if ();

  div_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .cpu_clk_50M (clk),
    .cpu_rst_n   (rst_n),
    .div_if      (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference quotient/remainder from 64-bit arithmetic (truncating division).
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Cycle model: accept from idle, result appears after a fixed latency.
  logic        m_ready, m_busy, m_byz, m_pbyz;
  logic [63:0] m_result, m_pend;
  int          m_cd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready <= 1'b0; m_busy <= 1'b0; m_byz <= 1'b0; m_result <= 64'd0;
      m_pend <= 64'd0; m_pbyz <= 1'b0; m_cd <= 0;
    end else if (u_if.div_cancel) begin
      m_ready <= 1'b0; m_busy <= 1'b0; m_byz <= 1'b0; m_result <= 64'd0; m_cd <= 0;
    end else if (!m_busy) begin
      if (u_if.div_start) begin
        m_busy <= 1'b1;
        if (u_if.div_opdata2 == 32'd0) begin
          m_cd <= 1; m_pend <= 64'd0; m_pbyz <= 1'b1;
        end else begin
          m_cd <= LAT; m_pbyz <= 1'b0;
          m_pend <= ref_div(u_if.div_opdata1, u_if.div_opdata2, u_if.div_signed);
        end
      end
    end else if (!m_ready) begin
      if (m_cd == 1) begin
        m_ready <= 1'b1; m_result <= m_pend; m_byz <= m_pbyz;
      end
      m_cd <= m_cd - 1;
    end else if (!u_if.div_start) begin
      m_ready <= 1'b0; m_busy <= 1'b0; m_byz <= 1'b0; m_result <= 64'd0;
    end
  end

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Drive one operation; check latency, result, hold behaviour and release.
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [63:0] exp_res, input logic exp_byz,
                        input int exp_lat, input int hold);
    int n;
    @(posedge clk); #2;
    u_if.div_start = 1'b1; u_if.div_signed = s;
    u_if.div_opdata1 = a;  u_if.div_opdata2 = b;
    @(posedge clk);
    #2;
    u_if.div_opdata1 = 32'hDEAD_BEEF; u_if.div_opdata2 = 32'h0000_0013;
    u_if.div_signed = ~s;
    n = 0;
    for (int i = 1; i <= 80; i++) begin
      @(posedge clk); #1;
      n = i;
      if (u_if.div_ready) break;
    end
    check({name, "_latency"}, 96'(n), 96'(exp_lat));
    check({name, "_result"}, 96'(u_if.div_result), 96'(exp_res));
    check({name, "_by_zero"}, 96'(u_if.div_by_zero), 96'(exp_byz));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({name, "_hold_ready"}, 96'(u_if.div_ready), 96'd1);
    end
    #1 u_if.div_start = 1'b0;
    @(posedge clk); #1;
    check({name, "_release"}, {31'd0, u_if.div_ready, u_if.div_result}, 96'd0);
  endtask

  initial begin
    u_if.div_start = 1'b0; u_if.div_signed = 1'b0; u_if.div_cancel = 1'b0;
    u_if.div_opdata1 = 32'd0; u_if.div_opdata2 = 32'd0;
    rst_n = 1'b0;

    fork
      forever begin
        @(negedge clk);
        check("cycle_model",
              {29'd0, u_if.div_ready, u_if.div_busy, u_if.div_by_zero, u_if.div_result},
              {29'd0, m_ready, m_busy, m_byz, m_result});
      end
    join_none

    // Pin the reference model against hand-computed values.
    check("model_100_7",  96'(ref_div(32'd100, 32'd7, 1'b0)), {32'd0, 32'd2, 32'd14});
    check("model_m7_2",   96'(ref_div(32'hFFFF_FFF9, 32'd2, 1'b1)),
          {32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
    check("model_ovf",    96'(ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1)),
          {32'd0, 32'h0, 32'h8000_0000});

    #13;
    check("reset_outputs",
          {29'd0, u_if.div_ready, u_if.div_busy, u_if.div_by_zero, u_if.div_result}, 96'd0);
    #10 rst_n = 1'b1;

    run_op("u100_7",  32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 1'b0, LAT, 0);
    run_op("s_m7_2",  32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0, LAT, 0);
    run_op("s_7_m2",  32'd7, 32'hFFFF_FFFE, 1'b1, {32'h0000_0001, 32'hFFFF_FFFD}, 1'b0, LAT, 1);
    run_op("s_ovf",   32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0, 32'h8000_0000}, 1'b0, LAT, 0);
    run_op("u_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, {32'h0, 32'hFFFF_FFFF}, 1'b0, LAT, 0);
    run_op("u_1_max", 32'd1, 32'hFFFF_FFFF, 1'b0, {32'd1, 32'd0}, 1'b0, LAT, 0);
    run_op("div0",    32'd1234, 32'd0, 1'b0, 64'd0, 1'b1, 1, 5);

    // Cancel ten iterations into an operation.
    @(posedge clk); #2;
    u_if.div_start = 1'b1; u_if.div_signed = 1'b0;
    u_if.div_opdata1 = 32'd1000; u_if.div_opdata2 = 32'd3;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #2 u_if.div_cancel = 1'b1; u_if.div_start = 1'b0;
    @(posedge clk); #1;
    check("cancel_busy", 96'(u_if.div_busy), 96'd0);
    #1 u_if.div_cancel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("cancel_no_ready", 96'(u_if.div_ready), 96'd0);
    end
    run_op("after_cancel", 32'd50, 32'd5, 1'b0, {32'd0, 32'd10}, 1'b0, LAT, 0);

    // Asynchronous reset in the middle of an operation.
    @(posedge clk); #2;
    u_if.div_start = 1'b1; u_if.div_signed = 1'b1;
    u_if.div_opdata1 = 32'd1000; u_if.div_opdata2 = 32'd7;
    repeat (6) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_reset",
          {29'd0, u_if.div_ready, u_if.div_busy, u_if.div_by_zero, u_if.div_result}, 96'd0);
    u_if.div_start = 1'b0;
    #14 rst_n = 1'b1;
    run_op("after_reset", 32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 1'b0, LAT, 0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Standalone multi-cycle 32-bit integer divider; the responder side of the execute stage's DIV/DIVU start/ready handshake.
- Execute stage raises div_start with operands and stalls until div_ready.
- Block returns {remainder, quotient} for the HI/LO write path.
- Supports signed (DIV) and unsigned (DIVU), divide-by-zero detection, and pipeline-flush cancel.

Parameters:
- DATA_W, 32, operand width; result is 2*DATA_W.
- CNT_W, 6, iteration counter width; must hold DATA_W.

Ports:
- cpu_clk_50M  in  1  system clock, rising edge.
- cpu_rst_n  in  1  reset, asynchronous, active-low.
- div_start  in  1  request; held high by the initiator until it sees div_ready.
- div_signed  in  1  1 = DIV (signed), 0 = DIVU; sampled with operands.
- div_cancel  in  1  flush (exception or branch squash); abort current operation.
- div_opdata1  in  32  dividend.
- div_opdata2  in  32  divisor.
- div_ready  out  1  result valid.
- div_busy  out  1  state is not FREE.
- div_by_zero  out  1  qualifies div_ready: divisor was 0.
- div_result  out  64  [63:32] remainder (HI), [31:0] quotient (LO).

Behaviour:
- Reset:
  - cpu_rst_n low forces state = FREE immediately (asynchronous).
  - div_ready = 0, div_busy = 0, div_by_zero = 0, div_result = 64'h0.
  - Counter and internal operand registers = 0.
- States: FREE, BY_ZERO, ON, END (2-bit encoding). div_ready = 1 only in END.
- FREE:
  - On a clock edge (E0) with div_start = 1 and div_cancel = 0, latch div_signed, the operand sign bits, and the operands.
  - Divisor == 0: go to BY_ZERO.
  - Divisor != 0: go to ON. Store operand magnitudes: two's complement if signed and bit31 = 1, else raw. Counter = 0; 65-bit partial remainder/quotient register = {33'b0, |dividend|}.
- BY_ZERO: next edge goes to END with div_result = 0 and div_by_zero = 1. div_ready is visible one cycle after E0.
- ON (radix-2 restoring division):
  - Each edge: trial = partial_rem[64:32] - {1'b0, |divisor|}.
  - trial non-negative: shift in quotient bit 1 and keep the difference.
  - trial negative: shift left and insert 0.
  - Counter increments by 1 per edge; 32 iterations run on edges E1..E32.
  - At counter == 32 (edge E33), apply the sign fix:
    - Quotient negated if signed and the operand signs differ.
    - Remainder negated if signed and the dividend is negative; the remainder takes the dividend's sign.
  - Load div_result and go to END. div_ready is visible 33 cycles after E0.
- END:
  - div_ready = 1 and div_result holds its value.
  - If div_start = 0 on an edge: go to FREE, div_ready = 0, div_result = 0, div_by_zero = 0.
  - If div_start stays 1: stay in END.
- Overflow case: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0. No trap.
- div_cancel = 1 on any edge in any state: next state is FREE and all outputs return to their reset values. Cancel takes priority over start and over completion.
- Operands are sampled only at E0. Changes on div_opdata1/2 during ON or END are ignored.
- The signed-ness and sign bits used for the sign fix are the latched copies, never the live inputs.
- A new start is accepted only from FREE. A back-to-back request needs one FREE cycle after END.

Optional Feature:
- Macro: DIV_RADIX4_EN.
- Defined:
  - Radix-4 iteration. Precompute |divisor|×1, ×2, ×3 (34-bit) at E0.
  - Each ON edge subtracts the largest non-negative trial, shifts 2 quotient bits, and increments the counter by 2.
  - Completion at counter == 32: 16 iterations plus the sign-fix edge, so div_ready is visible 17 cycles after E0.
- Undefined: radix-2, 33-cycle latency as described above.
- Results are bit-identical in both builds.

Test Plan:
- Unsigned 100 / 7:
  - div_start = 1, div_signed = 0.
  - Expect div_ready high 33 cycles after acceptance (17 with DIV_RADIX4_EN), div_result = {32'd2, 32'd14}, div_by_zero = 0.
  - Drop div_start: div_ready low and div_result = 0 the next cycle.
- Signed -7 / 2 (0xFFFFFFF9 / 0x2):
  - Expect quotient 0xFFFFFFFD and remainder 0xFFFFFFFF.
  - Also 7 / -2: expect quotient 0xFFFFFFFD and remainder 0x00000001.
- Signed 0x80000000 / 0xFFFFFFFF:
  - Expect {0x00000000, 0x80000000}.
  - Unsigned 0xFFFFFFFF / 0x1: expect {0, 0xFFFFFFFF}.
- Divide by zero 1234 / 0:
  - Expect div_ready one cycle after acceptance, div_by_zero = 1, div_result = 0.
  - Hold div_start high 5 more cycles: div_ready stays 1 (state remains END).
- Cancel mid-operation:
  - Assert div_cancel for one cycle at counter == 10.
  - Expect div_busy = 0 and div_ready never asserted.
  - Immediately issue 50 / 5: expect {0, 10} with full latency.
- Asynchronous reset:
  - Pull cpu_rst_n low between clock edges during ON.
  - Expect div_busy, div_ready and div_result = 0 without waiting for a clock edge.
  - After release, 9 / 3 yields {0, 3}.
